// File: rtl/vga_regs_pkg.sv
// Shared constants for the VGA display register bank: port offsets, commit FSM states, BCD limit.
package vga_regs_pkg;

  // Offsets relative to BASE_PORT + N_NIB
  localparam int OFS_FLAGS  = 0;
  localparam int OFS_CURSOR = 1;
  localparam int OFS_PROG   = 2;
  localparam int OFS_COMMIT = 3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_e;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/vga_commit_ctrl.sv
// Commit handshake FSM: arms on a commit-port write, fires on vblank start or after TIMEOUT_CYC cycles.
module vga_commit_ctrl
  import vga_regs_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic vblank_start,
  output logic commit_pending,
  output logic commit,
  output logic commit_done
);

  localparam int              CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);

  commit_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          pending_q;
  logic          done_q;

  // Commit strobe qualifies the live-bank load on this same edge.
  assign commit = (state_q == ARMED) && (vblank_start || (cnt_q == CNT_LAST));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit;
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q   <= ARMED;
            cnt_q     <= '0;
            pending_q <= 1'b1;
          end
        end
        ARMED: begin
          if (commit) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign commit_pending = pending_q;
  assign commit_done    = done_q;

endmodule

// File: rtl/vga_shadow_regs.sv
// Shadow/live display register bank with frame-synchronous atomic commit.
// Optional BCD nibble checking under macro VGA_REGS_BCD_CHECK_EN.
module vga_shadow_regs
  import vga_regs_pkg::*;
#(
  parameter int         N_NIB       = 18,
  parameter logic [7:0] BASE_PORT   = 8'h04,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic                 reloj_nexys,
  input  logic                 reset_total,
  input  logic                 write_strobe,
  input  logic [7:0]           id_port,
  input  logic [7:0]           dato,
  input  logic                 vblank_start,
  output logic [4*N_NIB-1:0]   digits,
  output logic                 tempo,
  output logic                 formatto,
  output logic [2:0]           dir_cursor,
  output logic [7:0]           direccion_prog,
  output logic                 commit_pending,
  output logic                 commit_done,
  output logic                 bcd_error
);

  localparam int MAP_TOP = int'(BASE_PORT) + N_NIB;

  if (N_NIB < 1 || N_NIB > 64) begin : g_bad_nnib
    $error("vga_shadow_regs: N_NIB out of range 1..64");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("vga_shadow_regs: TIMEOUT_CYC must be at least 2");
  end
  if (MAP_TOP + OFS_COMMIT >= 255) begin : g_bad_map
    $error("vga_shadow_regs: port map does not fit below 8'hFF");
  end

  localparam logic [7:0] P_FLAGS  = 8'(MAP_TOP + OFS_FLAGS);
  localparam logic [7:0] P_CURSOR = 8'(MAP_TOP + OFS_CURSOR);
  localparam logic [7:0] P_PROG   = 8'(MAP_TOP + OFS_PROG);
  localparam logic [7:0] P_COMMIT = 8'(MAP_TOP + OFS_COMMIT);

  logic [7:0] nib_ofs;
  logic       nib_hit;
  logic       nib_ok;
  logic       arm;
  logic       commit;

  assign nib_ofs = id_port - BASE_PORT;
  assign nib_hit = write_strobe && (id_port >= BASE_PORT) && (int'(nib_ofs) < N_NIB);
  assign arm     = write_strobe && (id_port == P_COMMIT);

`ifdef VGA_REGS_BCD_CHECK_EN
  logic bcd_error_q;
  assign nib_ok = is_bcd(dato[3:0]);

  always_ff @(posedge reloj_nexys or negedge reset_total) begin
    if (!reset_total) bcd_error_q <= 1'b0;
    else              bcd_error_q <= bcd_error_q | (nib_hit & ~nib_ok);
  end

  assign bcd_error = bcd_error_q;
`else
  assign nib_ok    = 1'b1;
  assign bcd_error = 1'b0;
`endif

  logic [4*N_NIB-1:0] shadow_dig_q, shadow_dig_d, live_dig_q;
  logic               shadow_tempo_q, shadow_tempo_d, live_tempo_q;
  logic               shadow_fmt_q, shadow_fmt_d, live_fmt_q;
  logic [2:0]         shadow_cur_q, shadow_cur_d, live_cur_q;
  logic [7:0]         shadow_prog_q, shadow_prog_d, live_prog_q;

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    shadow_dig_d   = shadow_dig_q;
    shadow_tempo_d = shadow_tempo_q;
    shadow_fmt_d   = shadow_fmt_q;
    shadow_cur_d   = shadow_cur_q;
    shadow_prog_d  = shadow_prog_q;
    for (int k = 0; k < N_NIB; k++) begin
      if (nib_hit && nib_ok && (nib_ofs == 8'(k))) shadow_dig_d[4*k +: 4] = dato[3:0];
    end
    if (write_strobe) begin
      if (id_port == P_FLAGS) begin
        shadow_tempo_d = dato[4];
        shadow_fmt_d   = dato[0];
      end
      if (id_port == P_CURSOR) shadow_cur_d  = dato[2:0];
      if (id_port == P_PROG)   shadow_prog_d = dato;
    end
  end

  // NOTE: the banks are small flop arrays, not RAM, so they take the async reset like any other state.
  always_ff @(posedge reloj_nexys or negedge reset_total) begin
    if (!reset_total) begin
      shadow_dig_q   <= '0;
      shadow_tempo_q <= 1'b0;
      shadow_fmt_q   <= 1'b0;
      shadow_cur_q   <= '0;
      shadow_prog_q  <= '0;
      live_dig_q     <= '0;
      live_tempo_q   <= 1'b0;
      live_fmt_q     <= 1'b0;
      live_cur_q     <= '0;
      live_prog_q    <= '0;
    end else begin
      shadow_dig_q   <= shadow_dig_d;
      shadow_tempo_q <= shadow_tempo_d;
      shadow_fmt_q   <= shadow_fmt_d;
      shadow_cur_q   <= shadow_cur_d;
      shadow_prog_q  <= shadow_prog_d;
      // Live bank copies the pre-edge shadow, so a same-edge write waits for the next commit.
      if (commit) begin
        live_dig_q   <= shadow_dig_q;
        live_tempo_q <= shadow_tempo_q;
        live_fmt_q   <= shadow_fmt_q;
        live_cur_q   <= shadow_cur_q;
        live_prog_q  <= shadow_prog_q;
      end
    end
  end

  vga_commit_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_commit_ctrl (
    .clk            (reloj_nexys),
    .rst_n          (reset_total),
    .arm            (arm),
    .vblank_start   (vblank_start),
    .commit_pending (commit_pending),
    .commit         (commit),
    .commit_done    (commit_done)
  );

  assign digits         = live_dig_q;
  assign tempo          = live_tempo_q;
  assign formatto       = live_fmt_q;
  assign dir_cursor     = live_cur_q;
  assign direccion_prog = live_prog_q;

endmodule

// File: doc/vga_shadow_regs.md
# vga_shadow_regs

Parametrised, port-mapped display register bank that sits between the PicoBlaze output port bus and the VGA text/figure renderer. Time, date and chronometer values are written one BCD nibble at a time, along with flag, cursor and programming-field bytes. All writes land in a shadow bank. A handshake write to the commit port arms a transfer, and the shadow bank is copied atomically into the live bank at the next vertical-blank start, so a frame never shows a half-updated value. A timeout forces the commit if no frame boundary arrives.

## Interface
Parameters:
- N_NIB, 18: number of BCD digit nibbles. Range 1..64.
- BASE_PORT, 8'h04: id_port of nibble 0. Nibble k is at BASE_PORT+k.
- TIMEOUT_CYC, 2_000_000: forced-commit limit, in reloj_nexys cycles counted from arming. Must be ≥2.

Ports:
- reloj_nexys, in, 1: system clock; the only clock.
- reset_total, in, 1: asynchronous, active-low reset.
- write_strobe, in, 1: port write qualifier, one cycle per write.
- id_port, in, 8: port address.
- dato, in, 8: write data.
- vblank_start, in, 1: one-cycle pulse at the start of vertical blank, synchronous to reloj_nexys.
- digits, out, 4*N_NIB: live nibbles. Nibble k is at bits [4k+3:4k].
- tempo, out, 1: live AM/PM flag.
- formatto, out, 1: live 12/24 h flag.
- dir_cursor, out, 3: live cursor position.
- direccion_prog, out, 8: live programming-field code.
- commit_pending, out, 1: high while a commit is armed.
- commit_done, out, 1: one-cycle pulse marking a completed commit.
- bcd_error, out, 1: sticky BCD error flag. Present only under the macro below.

## Operation
Port map (P = BASE_PORT + N_NIB):
- BASE_PORT+k: shadow nibble k ← dato[3:0].
- P: shadow tempo ← dato[4]; shadow formatto ← dato[0].
- P+1: shadow cursor ← dato[2:0].
- P+2: shadow prog ← dato.
- P+3: commit port. dato is ignored.
- Any other address is ignored. The whole map must fit below 8'hFF; this is an elaboration check.

Reset (reset_total low):
- Shadow and live banks clear to 0.
- commit_pending=0, commit_done=0, bcd_error=0, FSM in IDLE, timeout counter 0.

FSM with states IDLE and ARMED:
- IDLE → ARMED on a commit-port write. The timeout counter clears to 0.
- ARMED → IDLE on vblank_start, or when the counter reaches TIMEOUT_CYC-1. On that edge the live bank is loaded from the shadow bank and commit_done pulses.
- A commit-port write while ARMED is ignored. Only one commit is outstanding, and the counter does not restart.
- Shadow writes are accepted in both states. Any write that lands before the commit edge is included in that commit.

Boundary cases:
- Commit-port write in the same cycle as vblank_start: arms only. The commit happens at the next vblank_start.
- Data-port write in the same cycle as the commit edge: the live bank takes the pre-write shadow value. The new value waits for the next commit.
- vblank_start in IDLE has no effect.
- Reset mid-ARMED abandons the commit. Live values are lost.

## Timing
- Shadow registers update on the rising edge that samples write_strobe high.
- commit_pending rises one edge after the commit write and falls on the commit edge.
- Live outputs change on the rising edge that samples vblank_start high while ARMED, so they are visible in the following cycle. commit_done is high for exactly that cycle.
- Forced commit happens TIMEOUT_CYC cycles after the arming edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
Macro VGA_REGS_BCD_CHECK_EN:
- Defined: a nibble write with dato[3:0] > 9 is dropped, so the shadow keeps its old value, and bcd_error is set. bcd_error clears only on reset. Flag, cursor and prog writes are not checked.
- Undefined: every nibble write is accepted, and bcd_error is tied to 0.

## Structure
- Package vga_regs_pkg holds:
  - the port offsets OFS_FLAGS=0, OFS_CURSOR=1, OFS_PROG=2, OFS_COMMIT=3, all relative to BASE_PORT+N_NIB;
  - the FSM state encoding (IDLE, ARMED);
  - the BCD limit constant 4'd9.
- Sub-module vga_commit_ctrl holds the FSM and the timeout counter, with $clog2(TIMEOUT_CYC) bits. Inputs are arm, vblank_start and reset. Outputs are commit_pending and the commit/commit_done pulses. The top level holds the banks and the address decode.

## Test plan
- Reset release: all outputs 0. Write nibble 0 = 4'h7 with no commit: digits stays 0 through 3 vblank pulses.
- Write nibbles 0 and 1 = 3 and 5, write the commit port, pulse vblank_start 10 cycles later: digits[7:0]=8'h53 in the cycle after the pulse, commit_done high for that one cycle, commit_pending low.
- Commit-port write in the same cycle as vblank_start: no commit. Commit occurs at the next pulse. A second commit write while ARMED produces no second commit_done.
- TIMEOUT_CYC=16 with no vblank: commit_done exactly 16 cycles after the arming edge, live bank loaded.
- With VGA_REGS_BCD_CHECK_EN, write nibble 2 = 4'hC: shadow unchanged, bcd_error=1 and stays 1 after commit. Without the macro, digits[11:8]=4'hC after commit.
- N_NIB=4, BASE_PORT=8'h20: port 8'h24 with dato=8'h11 sets tempo=1 and formatto=1 after commit. Port 8'h28 is ignored. Reset asserted while ARMED clears commit_pending asynchronously.
